fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL take parameter DWIDTH, default 7, the MSB index of the data word, so words are DWIDTH+1 bits.
REQ-002 The block SHALL take parameter NREQ, default 4, the number of requesters, legal values 2..8.
REQ-003 The block SHALL have port clk  input  1  the single clock, with all state updated on posedge.
REQ-004 The block SHALL have port rst  input  1  the asynchronous active-low reset.
REQ-005 The block SHALL have port req  input  NREQ  the per-requester write request, held high until granted.
REQ-006 The block SHALL have port req_data  input  NREQ*(DWIDTH+1)  the per-requester data word, with requester i in slice [i*(DWIDTH+1) +: DWIDTH+1] and held stable while req[i] is high.
REQ-007 The block SHALL have port fifo_full  input  1  the full flag from the downstream FIFO.
REQ-008 The block SHALL have port gnt  output  NREQ  the registered one-hot grant, high for exactly one cycle per accepted word.
REQ-009 The block SHALL have port fifo_wr_en  output  1  the registered write enable to the FIFO.
REQ-010 The block SHALL have port fifo_data_in  output  DWIDTH+1  the registered write data to the FIFO.
REQ-011 The block SHALL have port busy  output  1  which is high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE, WRITE and STALL with registered state.
REQ-013 In IDLE, when req is nonzero and fifo_full is low at the edge, the block SHALL go to WRITE and assert gnt[w], fifo_wr_en=1 and fifo_data_in=req_data slice w at that same edge.
REQ-014 In IDLE, when req is nonzero and fifo_full is high, the block SHALL go to STALL with no grant and no write.
REQ-015 In IDLE, when req is zero, the block SHALL stay in IDLE.
REQ-016 WRITE SHALL last exactly one cycle, after which the block returns to IDLE and clears gnt and fifo_wr_en, so writes occur at most once every 2 cycles and fifo_full settles before the next decision.
REQ-017 In STALL, the block SHALL stay while fifo_full is high, go to IDLE if req becomes zero, and otherwise arbitrate and enter WRITE exactly as in REQ-013.
REQ-018 Arbitration SHALL be round-robin: the winner w is the first requester with req set, searching from last_gnt+1 upward modulo NREQ.
REQ-019 last_gnt SHALL update to w only on entry to WRITE.
REQ-020 gnt SHALL be one-hot or zero, and fifo_wr_en SHALL equal the OR-reduction of gnt in every cycle.
REQ-021 The block SHALL never assert fifo_wr_en in a cycle following an edge at which fifo_full was sampled high.
REQ-022 A requester that drops req before being granted SHALL be dropped silently, with no grant and no write.
REQ-023 fifo_data_in SHALL hold its last written value while fifo_wr_en is low.

Reset
REQ-024 While rst is low, the block SHALL immediately, independent of clk, force state=IDLE, gnt=0, fifo_wr_en=0, fifo_data_in=0, busy=0 and last_gnt=NREQ-1, so requester 0 wins first.
REQ-025 When reset is asserted during WRITE or STALL, the in-flight grant and write SHALL be aborted in the same cycle, and no write SHALL occur until the first edge after rst rises.

Configuration
REQ-026 When macro FIFO_ARB_STATS_EN is defined, the block SHALL add output gnt_cnt  NREQ*8, holding one 8-bit counter per requester that increments on each grant to that requester, saturates at 255 and resets to 0.
REQ-027 When FIFO_ARB_STATS_EN is undefined, the gnt_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL drive req=4'b0001, data0=8'hA5, fifo_full=0 -> gnt=4'b0001, fifo_wr_en=1 and fifo_data_in=8'hA5 one cycle after the edge, then gnt=0 the next cycle.
REQ-029 The bench SHALL drive req=4'b1111 held, with each requester re-requesting after grant -> grants in order 0,1,2,3,0 with one write every 2 cycles.
REQ-030 The bench SHALL drive req=4'b0100 with fifo_full=1 for 5 cycles, then fifo_full=0 -> busy=1 and no write during the stall, then a single gnt=4'b0100 write after fifo_full=0 is sampled.
REQ-031 The bench SHALL drive req=4'b0010 into STALL, then drop req before fifo_full falls -> return to IDLE with zero grants and no write.
REQ-032 The bench SHALL drop rst mid-WRITE -> gnt, fifo_wr_en and fifo_data_in are 0 immediately, and after release the next grant goes to requester 0.
REQ-033 With FIFO_ARB_STATS_EN defined, the bench SHALL apply 300 grants to requester 1 -> gnt_cnt slice 1 = 255 and other slices = 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding one downstream FIFO port.
// Define FIFO_ARB_STATS_EN to add the per-requester grant counters (gnt_cnt).
module fifo_wr_arb #(
   parameter int DWIDTH = 7,
   parameter int NREQ   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req,
   input  logic [NREQ*(DWIDTH+1)-1:0]   req_data,
   input  logic                         fifo_full,
   output logic [NREQ-1:0]              gnt,
   output logic                         fifo_wr_en,
   output logic [DWIDTH:0]              fifo_data_in,
   output logic                         busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NREQ*8-1:0]            gnt_cnt
`endif
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, STALL} state_t;

   state_t            state_q, state_d;
   logic [LW-1:0]     last_q, last_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              wr_q, wr_d;
   logic [DWIDTH:0]   data_q, data_d;
   logic [LW-1:0]     win;
   logic [LW-1:0]     idx;
   logic              hit;
   logic              go;
   int                s;

   // Search starts just after the last winner, wrapping modulo NREQ.
   always_comb begin
      win = '0;
      hit = 1'b0;
      idx = '0;
      s   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         s = int'(last_q) + k;
         if (s >= NREQ) s = s - NREQ;
         idx = LW'(s);
         if (!hit && req[idx]) begin
            hit = 1'b1;
            win = idx;
         end
      end
   end

   always_comb begin
      go      = 1'b0;
      state_d = state_q;
      gnt_d   = '0;
      wr_d    = 1'b0;
      data_d  = data_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               if (fifo_full) state_d = STALL;
               else           go      = 1'b1;
            end
         end
         WRITE: state_d = IDLE;
         STALL: begin
            if (!hit)           state_d = IDLE;
            else if (!fifo_full) go     = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (go) begin
         state_d    = WRITE;
         gnt_d[win] = 1'b1;
         wr_d       = 1'b1;
         data_d     = req_data[win*(DWIDTH+1) +: (DWIDTH+1)];
         last_d     = win;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [NREQ-1:0][7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (go && cnt_q[win] != 8'hFF)
         cnt_d[win] = cnt_q[win] + 8'd1;
   end

   assign gnt_cnt = cnt_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= LW'(NREQ - 1);
         gnt_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
`ifdef FIFO_ARB_STATS_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
`ifdef FIFO_ARB_STATS_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt          = gnt_q;
   assign fifo_wr_en   = wr_q;
   assign fifo_data_in = data_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: vector table through a scoreboard
// queue, plus reset-abort and (with FIFO_ARB_STATS_EN) counter sequences.
module tb_fifo_wr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        fifo_full;
   logic [3:0]  gnt;
   logic        fifo_wr_en;
   logic [7:0]  fifo_data_in;
   logic        busy;
`ifdef FIFO_ARB_STATS_EN
   logic [31:0] gnt_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_wr_arb #(.DWIDTH(7), .NREQ(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .fifo_full    (fifo_full),
      .gnt          (gnt),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .gnt_cnt      (gnt_cnt)
`endif
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       full;
      logic [3:0] gnt;
      logic       wr;
      logic [7:0] data;
      logic       busy;
   } vec_t;

   vec_t tbl[29];
   vec_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Structural invariants sampled every cycle.
   always @(negedge clk) begin
      chk("wr_en_eq_or_gnt", {31'd0, fifo_wr_en}, {31'd0, |gnt});
      chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
   end

   function automatic vec_t mk(input logic r, input logic [3:0] q,
                               input logic f, input logic [3:0] g,
                               input logic w, input logic [7:0] d,
                               input logic b);
      vec_t v;
      v.rst = r; v.req = q; v.full = f; v.gnt = g;
      v.wr = w; v.data = d; v.busy = b;
      return v;
   endfunction

   initial begin
      vec_t e;
      int   ng;
      // reset and single write
      tbl[0]  = mk(0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0);
      tbl[1]  = mk(1, 4'b0001, 0, 4'b0001, 1, 8'hA5, 1);
      tbl[2]  = mk(1, 4'b0000, 0, 4'b0000, 0, 8'hA5, 0);
      // reset then round robin 0,1,2,3,0
      tbl[3]  = mk(0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0);
      tbl[4]  = mk(1, 4'b1111, 0, 4'b0001, 1, 8'hA5, 1);
      tbl[5]  = mk(1, 4'b1111, 0, 4'b0000, 0, 8'hA5, 0);
      tbl[6]  = mk(1, 4'b1111, 0, 4'b0010, 1, 8'hB1, 1);
      tbl[7]  = mk(1, 4'b1111, 0, 4'b0000, 0, 8'hB1, 0);
      tbl[8]  = mk(1, 4'b1111, 0, 4'b0100, 1, 8'hC2, 1);
      tbl[9]  = mk(1, 4'b1111, 0, 4'b0000, 0, 8'hC2, 0);
      tbl[10] = mk(1, 4'b1111, 0, 4'b1000, 1, 8'hD3, 1);
      tbl[11] = mk(1, 4'b1111, 0, 4'b0000, 0, 8'hD3, 0);
      tbl[12] = mk(1, 4'b1111, 0, 4'b0001, 1, 8'hA5, 1);
      tbl[13] = mk(1, 4'b0000, 0, 4'b0000, 0, 8'hA5, 0);
      // stall 5 cycles then write
      tbl[14] = mk(1, 4'b0100, 1, 4'b0000, 0, 8'hA5, 1);
      tbl[15] = mk(1, 4'b0100, 1, 4'b0000, 0, 8'hA5, 1);
      tbl[16] = mk(1, 4'b0100, 1, 4'b0000, 0, 8'hA5, 1);
      tbl[17] = mk(1, 4'b0100, 1, 4'b0000, 0, 8'hA5, 1);
      tbl[18] = mk(1, 4'b0100, 1, 4'b0000, 0, 8'hA5, 1);
      tbl[19] = mk(1, 4'b0100, 0, 4'b0100, 1, 8'hC2, 1);
      tbl[20] = mk(1, 4'b0000, 0, 4'b0000, 0, 8'hC2, 0);
      // stall then drop request
      tbl[21] = mk(1, 4'b0010, 1, 4'b0000, 0, 8'hC2, 1);
      tbl[22] = mk(1, 4'b0010, 1, 4'b0000, 0, 8'hC2, 1);
      tbl[23] = mk(1, 4'b0000, 1, 4'b0000, 0, 8'hC2, 0);
      tbl[24] = mk(1, 4'b0000, 0, 4'b0000, 0, 8'hC2, 0);
      // wrap-around search after last=2
      tbl[25] = mk(1, 4'b1011, 0, 4'b1000, 1, 8'hD3, 1);
      tbl[26] = mk(1, 4'b0011, 0, 4'b0000, 0, 8'hD3, 0);
      tbl[27] = mk(1, 4'b0011, 0, 4'b0001, 1, 8'hA5, 1);
      tbl[28] = mk(1, 4'b0000, 0, 4'b0000, 0, 8'hA5, 0);

      req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
      rst       = 1'b0;
      req       = 4'b0000;
      fifo_full = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 29; i++) begin
         rst       = tbl[i].rst;
         req       = tbl[i].req;
         fifo_full = tbl[i].full;
         exp_q.push_back(tbl[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_gnt", i), {28'd0, gnt}, {28'd0, e.gnt});
         chk($sformatf("v%0d_wr", i), {31'd0, fifo_wr_en}, {31'd0, e.wr});
         chk($sformatf("v%0d_data", i), {24'd0, fifo_data_in},
             {24'd0, e.data});
         chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, e.busy});
      end

      // reset in the middle of a write cycle
      req = 4'b0100;
      @(negedge clk);
      chk("mid_write_gnt", {28'd0, gnt}, 32'h4);
      chk("mid_write_data", {24'd0, fifo_data_in}, 32'hC2);
      rst = 1'b0;
      req = 4'b1111;
      #1;
      chk("rst_abort_gnt", {28'd0, gnt}, 32'h0);
      chk("rst_abort_wr", {31'd0, fifo_wr_en}, 32'h0);
      chk("rst_abort_data", {24'd0, fifo_data_in}, 32'h0);
      chk("rst_abort_busy", {31'd0, busy}, 32'h0);
      @(negedge clk);
      chk("rst_held_wr", {31'd0, fifo_wr_en}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_gnt", {28'd0, gnt}, 32'h1);
      chk("post_rst_data", {24'd0, fifo_data_in}, 32'hA5);
      req = 4'b0000;
      @(negedge clk);

`ifdef FIFO_ARB_STATS_EN
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0010;
      ng  = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (gnt[1]) ng++;
      end
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      chk("stats_grants_seen", ng, 300);
      chk("stats_cnt0", {24'd0, gnt_cnt[7:0]}, 32'd0);
      chk("stats_cnt1", {24'd0, gnt_cnt[15:8]}, 32'd255);
      chk("stats_cnt2", {24'd0, gnt_cnt[23:16]}, 32'd0);
      chk("stats_cnt3", {24'd0, gnt_cnt[31:24]}, 32'd0);
`else
      ng = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
